pad_scanner: RTL and testbench

//  Multi-pad serial game-controller scanner (NES 4021-style, SNES 16-bit) for the button input path.

---
 rtl/pad_scanner.sv | 126 ++++++++++++
 tb/tb_pad_scanner.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_scanner.sv
// pad_scanner: multi-pad serial game-controller scanner with frame debounce and press events
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   poll_en, scan_req   automatic scan enable, one-cycle immediate scan request
//   pad_data            serial data from each pad (active low), bit p = pad p
//   pad_latch, pad_clk  registered strobe/shift clock shared by all pads (pad_clk idles high)
//   busy                scan in progress
//   frame_valid         one-cycle pulse when buttons/pressed are updated
//   buttons, pressed    held buttons and rising-edge events, pad p at [p*N_BITS +: N_BITS]
module pad_scanner #(
    parameter int N_PADS   = 2,
    parameter int N_BITS   = 8,
    parameter int HALF_DIV = 256,
    parameter int POLL_DIV = 131072,
    parameter int DEBOUNCE = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       poll_en,
    input  logic                       scan_req,
    input  logic [N_PADS-1:0]          pad_data,
    output logic                       pad_latch,
    output logic                       pad_clk,
    output logic                       busy,
    output logic                       frame_valid,
    output logic [N_PADS*N_BITS-1:0]   buttons,
    output logic [N_PADS*N_BITS-1:0]   pressed
);
    localparam int W  = N_PADS * N_BITS;
    localparam int DW = $clog2(HALF_DIV);
    localparam int PW = $clog2(POLL_DIV);
    localparam int BW = $clog2(N_BITS);
    localparam logic [DW-1:0] DIV_MAX  = DW'(HALF_DIV - 1);
    localparam logic [PW-1:0] POLL_MAX = PW'(POLL_DIV - 1);
    localparam logic [BW-1:0] BIT_MAX  = BW'(N_BITS - 1);

    typedef enum logic [2:0] {IDLE, LATCH, SAMPLE, CLK_LO, DONE} state_t;

    state_t        state_q;
    logic [DW-1:0] div_q, div_d;
    logic [PW-1:0] poll_q, poll_d;
    logic          pending_q, pending_d;
    logic [BW-1:0] bit_q;
    logic [W-1:0]  raw_q, prev_q, buttons_q, pressed_q;
    logic          latch_q, clk_q, fv_q;
    logic          tick, poll_wrap, start;

    always_comb begin
        tick      = div_q == DIV_MAX;
        div_d     = tick ? '0 : div_q + 1'b1;
        poll_wrap = poll_en && poll_q == POLL_MAX;
        poll_d    = (poll_en && !poll_wrap) ? poll_q + 1'b1 : '0;
        start     = state_q == IDLE && tick && pending_q;
        // a new request in the same cycle as LATCH entry is kept for the next scan
        pending_d = (pending_q && !start) || scan_req || poll_wrap;
    end

    // raw_q/prev_q hold active-low frames, so all ones means nothing pressed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            poll_q    <= '0;
            pending_q <= 1'b0;
            bit_q     <= '0;
            raw_q     <= '1;
            prev_q    <= '1;
            buttons_q <= '0;
            pressed_q <= '0;
            latch_q   <= 1'b0;
            clk_q     <= 1'b1;
            fv_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            poll_q    <= poll_d;
            pending_q <= pending_d;
            fv_q      <= 1'b0;
            pressed_q <= '0;
            case (state_q)
                IDLE: if (start) begin
                    state_q <= LATCH;
                    latch_q <= 1'b1;
                    bit_q   <= '0;
                end
                // bit_q doubles as the two-tick latch counter
                LATCH: if (tick) begin
                    if (bit_q != '0) begin
                        state_q <= SAMPLE;
                        latch_q <= 1'b0;
                        bit_q   <= '0;
                    end else bit_q <= bit_q + 1'b1;
                end
                SAMPLE: if (tick) begin
                    for (int p = 0; p < N_PADS; p++) raw_q[p*N_BITS + int'(bit_q)] <= pad_data[p];
                    if (bit_q == BIT_MAX) state_q <= DONE;
                    else begin
                        state_q <= CLK_LO;
                        clk_q   <= 1'b0;
                    end
                end
                CLK_LO: if (tick) begin
                    state_q <= SAMPLE;
                    clk_q   <= 1'b1;
                    bit_q   <= bit_q + 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    fv_q    <= 1'b1;
                    prev_q  <= raw_q;
                    if (DEBOUNCE == 0 || raw_q == prev_q) begin
                        buttons_q <= ~raw_q;
                        pressed_q <= ~raw_q & ~buttons_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pad_latch   = latch_q;
    assign pad_clk     = clk_q;
    assign busy        = state_q != IDLE;
    assign frame_valid = fv_q;
    assign buttons     = buttons_q;
    assign pressed     = pressed_q;
endmodule

// File: tb/tb_pad_scanner.sv
// tb_pad_scanner: randomized scoreboard bench for pad_scanner (NES/debounced and SNES/undebounced instances)
module tb_pad_scanner;
    localparam int NP = 2, NB = 8, NB2 = 16, W = NP*NB, W2 = NP*NB2;

    logic clk = 1'b0, reset = 1'b1;
    logic poll_en = 1'b0, poll_en2 = 1'b0, scan_req = 1'b0, scan_req2 = 1'b0;
    logic [NP-1:0] pad_data, pad_data2;
    logic pad_latch, pad_clk, busy, frame_valid;
    logic pad_latch2, pad_clk2, busy2, frame_valid2;
    logic [W-1:0]  buttons, pressed;
    logic [W2-1:0] buttons2, pressed2;

    pad_scanner #(.N_PADS(NP), .N_BITS(NB), .HALF_DIV(2), .POLL_DIV(64), .DEBOUNCE(1)) dut (
        .clk(clk), .reset(reset), .poll_en(poll_en), .scan_req(scan_req), .pad_data(pad_data),
        .pad_latch(pad_latch), .pad_clk(pad_clk), .busy(busy), .frame_valid(frame_valid),
        .buttons(buttons), .pressed(pressed));

    pad_scanner #(.N_PADS(NP), .N_BITS(NB2), .HALF_DIV(2), .POLL_DIV(64), .DEBOUNCE(0)) dut16 (
        .clk(clk), .reset(reset), .poll_en(poll_en2), .scan_req(scan_req2), .pad_data(pad_data2),
        .pad_latch(pad_latch2), .pad_clk(pad_clk2), .busy(busy2), .frame_valid(frame_valid2),
        .buttons(buttons2), .pressed(pressed2));

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pattern is the active-high set of held buttons the player presses
    typedef struct packed { logic [W2-1:0] b; logic [W2-1:0] p; } exp_t;
    exp_t q[$], q2[$];
    logic [W-1:0]  pat  = '0;
    logic [W2-1:0] pat2 = '0;
    logic [W2-1:0] m_btn = '0, m_prev = '0, m_btn2 = '0;

    task automatic expect_frame(input bit which, input logic [W2-1:0] f);
        exp_t e;
        if (!which) begin
            e.p = '0;
            if (f == m_prev) begin
                e.p   = f & ~m_btn;
                m_btn = f;
            end
            e.b    = m_btn;
            m_prev = f;
            q.push_back(e);
        end else begin
            e.p    = f & ~m_btn2;
            m_btn2 = f;
            e.b    = f;
            q2.push_back(e);
        end
    endtask

    // 4021-style pads: parallel load while latch high, shift toward bit 0 on pad_clk rising
    logic [NB-1:0]  sr  [NP] = '{default: '1};
    logic [NB2-1:0] sr2 [NP] = '{default: '1};

    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch) begin
            for (int p = 0; p < NP; p++) sr[p] = ~pat[p*NB +: NB];
            expect_frame(1'b0, W2'(pat));
        end else for (int p = 0; p < NP; p++) sr[p] = {1'b1, sr[p][NB-1:1]};
    end

    always @(posedge pad_latch2 or posedge pad_clk2) begin
        if (pad_latch2) begin
            for (int p = 0; p < NP; p++) sr2[p] = ~pat2[p*NB2 +: NB2];
            expect_frame(1'b1, pat2);
        end else for (int p = 0; p < NP; p++) sr2[p] = {1'b1, sr2[p][NB2-1:1]};
    end

    always_comb begin
        pad_data  = '0;
        pad_data2 = '0;
        for (int p = 0; p < NP; p++) begin
            pad_data[p]  = sr[p][0];
            pad_data2[p] = sr2[p][0];
        end
    end

    // Monitor: waveform timing per frame plus scoreboard pop on frame_valid
    int cyc = 0;
    int lat_start [2] = '{0, 0}, lat_len [2] = '{0, 0}, lo_cnt [2] = '{0, 0};
    int lo_len [2] = '{0, 0}, lo_bad [2] = '{0, 0}, fv_n [2] = '{0, 0}, rise_n [2] = '{0, 0};
    logic pl_d [2] = '{1'b0, 1'b0}, pc_d [2] = '{1'b1, 1'b1};
    int rise_t[$];

    always @(negedge clk) begin : mon
        logic pl, pc, fv;
        logic [W2-1:0] b, pr;
        exp_t e;
        bit have;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            pl = i ? pad_latch2 : pad_latch;
            pc = i ? pad_clk2 : pad_clk;
            fv = i ? frame_valid2 : frame_valid;
            b  = i ? buttons2 : W2'(buttons);
            pr = i ? pressed2 : W2'(pressed);
            if (reset) begin
                lat_len[i] = 0;
                lo_len[i]  = 0;
            end else begin
                if (pl && !pl_d[i]) begin
                    lat_start[i] = cyc;
                    lat_len[i]   = 0;
                    lo_cnt[i]    = 0;
                    lo_bad[i]    = 0;
                    rise_n[i]++;
                    if (i == 0) rise_t.push_back(cyc);
                end
                if (pl) lat_len[i]++;
                if (!pc) lo_len[i]++;
                else begin
                    if (!pc_d[i]) begin
                        lo_cnt[i]++;
                        if (lo_len[i] != 2) lo_bad[i]++;
                    end
                    lo_len[i] = 0;
                end
                if (fv) begin
                    fv_n[i]++;
                    chk(i ? "latency16" : "latency", cyc - lat_start[i], i ? 67 : 35);
                    chk("latch_len", lat_len[i], 4);
                    chk(i ? "clk_pulses16" : "clk_pulses", lo_cnt[i], i ? 15 : 7);
                    chk("pulse_width_errs", lo_bad[i], 0);
                    have = i ? q2.size() != 0 : q.size() != 0;
                    if (!have) chk("unexpected_frame", 1, 0);
                    else begin
                        if (i) e = q2.pop_front();
                        else e = q.pop_front();
                        chk(i ? "buttons16" : "buttons", b, e.b);
                        chk(i ? "pressed16" : "pressed", pr, e.p);
                    end
                end else chk(i ? "pressed16_idle" : "pressed_idle", pr, 0);
            end
            pl_d[i] = pl;
            pc_d[i] = pc;
        end
    end

    task automatic wait_frame(input bit which, input int budget);
        int s, n;
        s = fv_n[which];
        n = 0;
        while (fv_n[which] == s && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("frame_timeout", 32'(n < budget), 1);
    endtask

    task automatic pulse_req(input bit which);
        @(posedge clk);
        #2;
        if (which) scan_req2 = 1'b1;
        else scan_req = 1'b1;
        @(posedge clk);
        #2;
        scan_req  = 1'b0;
        scan_req2 = 1'b0;
    endtask

    task automatic scan(input bit which);
        pulse_req(which);
        wait_frame(which, 200);
        repeat (3) @(posedge clk);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, n0, s;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_latch", 32'(pad_latch), 0);
        chk("rst_clk", 32'(pad_clk), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fv", 32'(frame_valid), 0);
        chk("rst_buttons", W2'(buttons), 0);
        chk("rst_buttons16", buttons2, 0);
        reset = 1'b0;

        // idle pads, then two identical frames with A and R held, then a one-frame glitch
        scan(0);
        pat = 16'h0081;
        scan(0);
        scan(0);
        pat = 16'h0089;
        scan(0);
        pat = 16'h0081;
        scan(0);
        scan(0);

        // requests while busy collapse into one extra scan
        n0 = rise_n[0];
        pulse_req(0);
        n = 0;
        while (!busy && n < 20) begin
            @(posedge clk);
            n++;
        end
        chk("busy_seen", 32'(busy), 1);
        repeat (3) begin
            repeat (3) @(posedge clk);
            pulse_req(0);
        end
        wait_frame(0, 200);
        wait_frame(0, 200);
        repeat (100) @(posedge clk);
        chk("extra_scans", rise_n[0] - n0, 2);

        // randomized patterns, sometimes repeated so debounce accepts them
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(1) == 1) pat = W'($urandom);
            scan(0);
        end

        // automatic polling
        pat = W'($urandom);
        n0 = rise_t.size();
        @(posedge clk);
        #2;
        poll_en = 1'b1;
        n = 0;
        while (rise_t.size() < n0 + 4 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #2;
        poll_en = 1'b0;
        chk("poll_timeout", 32'(n < 400), 1);
        for (int i = 1; i < 4; i++)
            if (rise_t.size() > n0 + i) chk("poll_interval", rise_t[n0+i] - rise_t[n0+i-1], 64);
        wait_frame(0, 200);
        repeat (80) @(posedge clk);

        // reset in the middle of LATCH aborts the frame
        pulse_req(0);
        n = 0;
        while (!pad_latch && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("latch_seen", 32'(pad_latch), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_latch", 32'(pad_latch), 0);
        chk("abort_clk", 32'(pad_clk), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_buttons", W2'(buttons), 0);
        q.delete();
        q2.delete();
        m_btn  = '0;
        m_prev = '0;
        m_btn2 = '0;
        s = fv_n[0];
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (80) @(posedge clk);
        chk("no_frame_after_abort", fv_n[0] - s, 0);

        // 16-bit undebounced pads: pad1 bit 15
        pat2 = 32'h8000_0000;
        scan(1);
        scan(1);
        for (int i = 0; i < 4; i++) begin
            pat2 = $urandom;
            scan(1);
        end

        repeat (10) @(posedge clk);
        chk("queue_empty", 32'(q.size()), 0);
        chk("queue16_empty", 32'(q2.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
